mul_sequencer: RTL and testbench
================================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal range 4..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  execute stage holds a valid ALU instruction.
REQ-005 ALUControl  input  3  ALU operation from the decoder; 3'b010 = multiply.
REQ-006 flush  input  1  pipeline flush; aborts the operation in flight.
REQ-007 A  input  WIDTH  multiplicand (SrcA).
REQ-008 B  input  WIDTH  multiplier (SrcB).
REQ-009 stall  output  1  freezes IF/ID/EX while the multiply runs.
REQ-010 busy  output  1  high in RUN and DONE.
REQ-011 done  output  1  one-cycle pulse; result valid in this cycle.
REQ-012 result  output  WIDTH  low WIDTH bits of A*B.

Function
REQ-013 States: IDLE, RUN, DONE; 2-bit encoded state register.
REQ-014 Accept condition: state==IDLE, start==1, ALUControl==3'b010, flush==0.
REQ-015 On accept: latch A into the multiplicand register and B into the multiplier register, clear the accumulator and the iteration counter, go to RUN.
REQ-016 Start with any other ALUControl value: no state change, stall=0.
REQ-017 RUN, each cycle: if multiplier[0]==1, accumulator += multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1; counter += 1.
REQ-018 Counter width: clog2(WIDTH+1) bits; RUN lasts exactly WIDTH cycles, with no early termination on a zero multiplier.
REQ-019 Leave RUN for DONE on the cycle the counter reaches WIDTH-1, after that cycle's add.
REQ-020 DONE: done=1, result=accumulator, stall=0; next state IDLE unconditionally.
REQ-021 Start or ALUControl seen in RUN or DONE is ignored; the DONE cycle is the multiply instruction leaving EX.
REQ-022 stall = (accept condition) OR (state==RUN); it is combinational, so stall rises in the accept cycle.
REQ-023 Total latency: accept cycle + WIDTH RUN cycles; done is asserted on cycle WIDTH+1 after accept, with accept = cycle 0.
REQ-024 Arithmetic: result equals (A*B) mod 2^WIDTH, identical for signed and unsigned operands; overflow is silently discarded.
REQ-025 Operands are sampled only at accept; later changes on A/B have no effect.
REQ-026 result register holds its value after DONE until the next DONE; it does not change during RUN.
REQ-027 flush in RUN or DONE: next state IDLE, no done pulse, result unchanged, stall=0 in the following cycle.
REQ-028 flush together with an accept condition: no accept, state stays IDLE, stall=0.
REQ-029 Back-to-back multiplies: a new accept is possible in the first IDLE cycle after DONE; there are no idle-gap requirements beyond that.

Reset
REQ-030 rst has priority over flush and start; effective at the next rising edge.
REQ-031 After reset: state=IDLE, stall=0, busy=0, done=0, result=0, and counter, accumulator and operand registers all 0.
REQ-032 rst asserted mid-RUN aborts the operation; no done pulse follows the release of reset.

Verification
REQ-033 WIDTH=32: A=7, B=6, start with ALUControl=010 -> stall high for cycles 0..32, done=1 and result=42 at cycle 33, stall=0 at cycle 33.
REQ-034 A=32'hFFFFFFFF, B=32'hFFFFFFFF -> result=32'h00000001; A=32'h80000000, B=2 -> result=0; A=0x12345678, B=0 -> result=0, still after the full 33-cycle latency.
REQ-035 start with ALUControl=000 (add) -> stall=0, busy=0, no done; then a multiply with A=-3, B=5 -> result=32'hFFFFFFF1.
REQ-036 flush at cycle 10 of RUN -> IDLE at cycle 11, no done pulse, result keeps the previous value; flush coincident with a start -> no accept.
REQ-037 rst at cycle 5 of RUN -> all outputs at reset values the next cycle; a new multiply 3*3 then returns 9.
REQ-038 Two multiplies back-to-back (4*5 then 6*7), with A/B toggled randomly during RUN -> results 20 then 42; the second accept occurs one cycle after the first done.

Source files
------------

// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-and-add multiplier for a pipelined core.
// On a multiply in the execute stage it stalls the front end for WIDTH
// iterations. It then presents the low WIDTH bits of A*B for one cycle,
// while the multiply instruction leaves EX.
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic             flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int            CW        = $clog2(WIDTH + 1);
    localparam logic [2:0]    ALU_MUL   = 3'b010;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;     // multiplicand, shifts left
    logic [WIDTH-1:0] mplier_q, mplier_d;   // multiplier, shifts right
    logic [WIDTH-1:0] acc_q, acc_d;         // running partial product
    logic [WIDTH-1:0] result_q, result_d;   // last delivered product
    logic [CW-1:0]    cnt_q, cnt_d;         // iterations completed
    logic             accept;

    // A multiply is taken only from IDLE, and never when the slot is flushed
    assign accept = (state_q == S_IDLE) && start &&
                    (ALUControl == ALU_MUL) && !flush;

    // Next-state, datapath update and output decode
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        stall    = accept;
        busy     = 1'b0;
        done     = 1'b0;
        result   = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mcand_d  = A;
                    mplier_d = B;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (flush) begin
                    // Abandon the operation; operand state is dead anyway
                    state_d = S_IDLE;
                end else begin
                    // Always run all WIDTH iterations, even if the multiplier
                    // becomes zero early, so that latency stays fixed
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                busy    = 1'b1;
                state_d = S_IDLE;
                // A flush in this cycle kills the instruction: no pulse, and
                // the previously delivered result stays visible
                if (!flush) begin
                    done     = 1'b1;
                    result   = acc_q;
                    result_d = acc_q;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer at WIDTH=32: a vector table of products
// plus hand-written sequences for flush, reset and back-to-back cases.
module tb_mul_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   alu;
    logic         flush;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] last_result;

    mul_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ALUControl (alu),
        .flush      (flush),
        .A          (a_in),
        .B          (b_in),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply and follow it through its full fixed latency
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input bit toggle, input string tag);
        int bad_run = 0;
        int bad_done = 0;
        int bad_res = 0;
        step();
        start = 1'b1; alu = 3'b010; flush = 1'b0; a_in = a; b_in = b;
        #1;
        chk({tag, " stall@accept"}, 64'(stall), 64'd1);
        chk({tag, " busy@accept"},  64'(busy),  64'd0);
        for (int c = 1; c <= W; c++) begin
            step();
            if (toggle) begin
                start = 1'($urandom_range(0, 1));
                alu   = 3'($urandom_range(0, 7));
                a_in  = $urandom;
                b_in  = $urandom;
            end else begin
                start = 1'b0;
                alu   = 3'b000;
            end
            #1;
            if (!stall || !busy) bad_run++;
            if (done) bad_done++;
            if (result !== last_result) bad_res++;
        end
        chk({tag, " stall/busy in run"}, 64'(bad_run),  64'd0);
        chk({tag, " early done"},        64'(bad_done), 64'd0);
        chk({tag, " result held in run"}, 64'(bad_res), 64'd0);
        step();
        #1;
        chk({tag, " done@latency"},  64'(done),   64'd1);
        chk({tag, " result"},        64'(result), 64'(exp));
        chk({tag, " stall@done"},    64'(stall),  64'd0);
        chk({tag, " busy@done"},     64'(busy),   64'd1);
        $display("mul %s: %08h * %08h -> %08h (expected %08h)", tag, a, b, result, exp);
        last_result = exp;
        start = 1'b0;
        alu   = 3'b000;
    endtask

    // Idle for n cycles: nothing may start and the result must hold
    task automatic idle_watch(input int n, input logic [W-1:0] exp, input string tag);
        int bad_act = 0;
        int bad_res = 0;
        for (int c = 0; c < n; c++) begin
            step();
            if (done || busy || stall) bad_act++;
            if (result !== exp) bad_res++;
        end
        chk({tag, " no activity"}, 64'(bad_act), 64'd0);
        chk({tag, " result held"}, 64'(bad_res), 64'd0);
    endtask

    initial begin
        vecs[0] = '{a: 32'd7,          b: 32'd6,          exp: 32'd42};
        vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   exp: 32'h00000001};
        vecs[2] = '{a: 32'h80000000,   b: 32'd2,          exp: 32'h00000000};
        vecs[3] = '{a: 32'h12345678,   b: 32'd0,          exp: 32'h00000000};
        vecs[4] = '{a: 32'hFFFFFFFD,   b: 32'd5,          exp: 32'hFFFFFFF1};
        vecs[5] = '{a: 32'd123,        b: 32'd456,        exp: 32'd56088};
        vecs[6] = '{a: 32'h00010000,   b: 32'h00010000,   exp: 32'h00000000};
        vecs[7] = '{a: 32'd0,          b: 32'hDEADBEEF,   exp: 32'h00000000};

        rst = 1'b1; start = 1'b0; alu = 3'b000; flush = 1'b0;
        a_in = '0; b_in = '0;
        last_result = '0;

        // Reset state
        step();
        step();
        chk("reset stall",  64'(stall),  64'd0);
        chk("reset busy",   64'(busy),   64'd0);
        chk("reset done",   64'(done),   64'd0);
        chk("reset result", 64'(result), 64'd0);
        rst = 1'b0;

        // Table of products
        for (int i = 0; i < 8; i++) begin
            do_mul(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
        end

        // Non-multiply ALU op is ignored
        step();
        start = 1'b1; alu = 3'b000; a_in = 32'd1; b_in = 32'd2;
        #1;
        chk("add stall", 64'(stall), 64'd0);
        chk("add busy",  64'(busy),  64'd0);
        step();
        start = 1'b0;
        idle_watch(40, last_result, "add");
        $display("add op ignored, result stays %08h", result);
        do_mul(32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0, "neg3x5");

        // Flush at cycle 10 of RUN
        step();
        start = 1'b1; alu = 3'b010; a_in = 32'd9; b_in = 32'd9;
        for (int c = 1; c <= 10; c++) begin
            step();
            start = 1'b0;
            if (c == 10) flush = 1'b1;
        end
        #1;
        chk("flush-cycle stall", 64'(stall), 64'd1);
        step();
        flush = 1'b0;
        #1;
        chk("post-flush busy",   64'(busy),   64'd0);
        chk("post-flush stall",  64'(stall),  64'd0);
        chk("post-flush result", 64'(result), 64'(last_result));
        idle_watch(40, last_result, "flush");
        $display("flush in run: aborted, result stays %08h", result);

        // Flush coincident with start
        step();
        start = 1'b1; alu = 3'b010; flush = 1'b1; a_in = 32'd2; b_in = 32'd2;
        #1;
        chk("flush+start stall", 64'(stall), 64'd0);
        step();
        start = 1'b0; flush = 1'b0;
        #1;
        chk("flush+start busy", 64'(busy), 64'd0);
        idle_watch(40, last_result, "flush+start");
        $display("flush with start: not accepted");

        // Reset at cycle 5 of RUN
        step();
        start = 1'b1; alu = 3'b010; a_in = 32'd11; b_in = 32'd13;
        for (int c = 1; c <= 5; c++) begin
            step();
            start = 1'b0;
            if (c == 5) rst = 1'b1;
        end
        step();
        rst = 1'b0;
        #1;
        chk("midrun-rst stall",  64'(stall),  64'd0);
        chk("midrun-rst busy",   64'(busy),   64'd0);
        chk("midrun-rst done",   64'(done),   64'd0);
        chk("midrun-rst result", 64'(result), 64'd0);
        last_result = '0;
        idle_watch(40, last_result, "midrun-rst");
        $display("reset in run: aborted, result %08h", result);
        do_mul(32'd3, 32'd3, 32'd9, 1'b0, "3x3");

        // Back-to-back with operand and control noise during RUN
        do_mul(32'd4, 32'd5, 32'd20, 1'b1, "b2b-1");
        do_mul(32'd6, 32'd7, 32'd42, 1'b1, "b2b-2");
        step();
        a_in = '0; b_in = '0;
        idle_watch(10, last_result, "final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
